// File: rtl/key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : key_schedule_ctrl
//  Purpose  : Sequencer for a one-round AES-128 key-expansion datapath.
//             Loads a cipher key, runs NR rounds through the external
//             datapath (feeding each result back as the next input), and
//             captures every round key into an (NR+1) x 128 store that the
//             cipher core reads by index through a registered read port.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NR          number of expansion rounds (1..10); NR+1 keys are stored
//    ROUND_LAT   datapath latency in clk edges, start to exp_key_out valid
//  Ports
//    clk          in   1    clock, rising edge
//    reset        in   1    asynchronous active-high reset
//    key_load     in   1    single-cycle request to expand key_in
//    key_in       in   128  cipher key, word0 in [127:96]
//    zeroize      in   1    (KS_ZEROIZE_EN only) wipe all key material
//    busy         out  1    expansion in progress
//    ready        out  1    full schedule stored and valid
//    exp_start    out  1    datapath enable
//    exp_key      out  128  round input key to the datapath
//    exp_rcon     out  8    round constant to the datapath
//    exp_key_out  in   128  datapath registered result
//    rk_rd_en     in   1    round-key read strobe
//    rk_idx       in   4    round-key index 0..NR
//    rk_data      out  128  registered read data (0 unless ready, idx<=NR)
//    rk_valid     out  1    one-cycle pulse marking rk_data valid
//  Build option
//    KS_ZEROIZE_EN  when defined, adds the zeroize input
// ============================================================================
module key_schedule_ctrl #(
    parameter int NR        = 10,
    parameter int ROUND_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_load,
    input  logic [127:0] key_in,
`ifdef KS_ZEROIZE_EN
    input  logic         zeroize,
`endif
    output logic         busy,
    output logic         ready,
    output logic         exp_start,
    output logic [127:0] exp_key,
    output logic [7:0]   exp_rcon,
    input  logic [127:0] exp_key_out,
    input  logic         rk_rd_en,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_data,
    output logic         rk_valid
);

    localparam int CW = (ROUND_LAT < 1) ? 1 : $clog2(ROUND_LAT + 1);
    localparam int IW = (NR < 1) ? 1 : $clog2(NR + 1);

    localparam logic [CW-1:0] c_lat  = CW'(ROUND_LAT);
    localparam logic [3:0]    c_nr   = 4'(NR);
    localparam logic [7:0]    c_rcon0 = 8'h01;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [3:0]    r_round;
    logic [CW-1:0] r_cnt;
    logic [127:0]  r_exp_key;
    logic [7:0]    r_exp_rcon;
    logic [127:0]  r_store [0:NR];
    logic [127:0]  r_rk_data;
    logic          r_rk_valid;

    logic w_zeroize;
    logic w_load;
    logic w_sample;
    logic w_last;
    logic w_rd_ok;

`ifdef KS_ZEROIZE_EN
    assign w_zeroize = zeroize;
`else
    assign w_zeroize = 1'b0;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    endfunction

    // A load is only honoured outside RUN; a request during RUN is dropped.
    assign w_load   = key_load && (r_state != c_run);
    // The datapath result becomes valid once ROUND_LAT edges have elapsed
    // since the round input was presented; it is captured on the next edge.
    assign w_sample = (r_state == c_run) && (r_cnt == c_lat);
    assign w_last   = w_sample && (r_round == c_nr);
    // Reads see the pre-edge state, so a read coinciding with a load still
    // returns the previous schedule.
    assign w_rd_ok  = (r_state == c_done) && (rk_idx <= c_nr);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (key_load) w_state_nxt = c_run;
            c_run:   if (w_last)   w_state_nxt = c_done;
            c_done:  if (key_load) w_state_nxt = c_run;
            default: w_state_nxt = c_idle;
        endcase
        if (w_zeroize) begin
            w_state_nxt = c_idle;
        end
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        busy      = 1'b0;
        ready     = 1'b0;
        exp_start = 1'b0;
        case (r_state)
            c_run: begin
                busy      = 1'b1;
                exp_start = 1'b1;
            end
            c_done:  ready = 1'b1;
            default: ;
        endcase
    end

    // ---------------- round sequencing and key store ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_round    <= 4'd0;
            r_cnt      <= '0;
            r_exp_key  <= '0;
            r_exp_rcon <= 8'h00;
            for (int i = 0; i <= NR; i++) begin
                r_store[i] <= '0;
            end
        end else if (w_zeroize) begin
            r_round    <= 4'd0;
            r_cnt      <= '0;
            r_exp_key  <= '0;
            r_exp_rcon <= c_rcon0;
            for (int i = 0; i <= NR; i++) begin
                r_store[i] <= '0;
            end
        end else if (w_load) begin
            r_store[0] <= key_in;
            r_exp_key  <= key_in;
            r_exp_rcon <= c_rcon0;
            r_round    <= 4'd1;
            r_cnt      <= '0;
        end else if (r_state == c_run) begin
            if (w_sample) begin
                r_store[r_round[IW-1:0]] <= exp_key_out;
                r_exp_key                <= exp_key_out;
                r_exp_rcon               <= xtime(r_exp_rcon);
                r_cnt                    <= '0;
                r_round                  <= r_round + 4'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // ---------------- registered read port ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rk_data  <= '0;
            r_rk_valid <= 1'b0;
        end else begin
            r_rk_valid <= rk_rd_en;
            if (w_zeroize) begin
                r_rk_data <= '0;
            end else if (rk_rd_en) begin
                r_rk_data <= w_rd_ok ? r_store[rk_idx[IW-1:0]] : '0;
            end
        end
    end

    assign exp_key  = r_exp_key;
    assign exp_rcon = r_exp_rcon;
    assign rk_data  = r_rk_data;
    assign rk_valid = r_rk_valid;

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_key_schedule_ctrl
//  Purpose  : Self-checking bench for key_schedule_ctrl with an attached
//             two-stage AES-128 key-expansion datapath and a word-level
//             FIPS-197 reference schedule.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_schedule_ctrl;

    localparam int NR  = 10;
    localparam int CPR = 3;   // clock cycles per round (ROUND_LAT + 1)

    logic         clk = 1'b0;
    logic         reset;
    logic         key_load;
    logic [127:0] key_in;
`ifdef KS_ZEROIZE_EN
    logic         zeroize;
`endif
    logic         busy, ready, exp_start;
    logic [127:0] exp_key;
    logic [7:0]   exp_rcon;
    logic [127:0] exp_key_out;
    logic         rk_rd_en;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         rk_valid;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   sbox [0:255];
    logic [7:0]   rcon_tbl [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    logic [127:0] ref_rk [0:NR];
    logic [127:0] m_rk [0:NR];
    logic         m_ready   = 1'b0;
    logic [127:0] m_rd_data = '0;

    always #5 clk = ~clk;

    key_schedule_ctrl #(.NR(NR), .ROUND_LAT(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .key_load    (key_load),
        .key_in      (key_in),
`ifdef KS_ZEROIZE_EN
        .zeroize     (zeroize),
`endif
        .busy        (busy),
        .ready       (ready),
        .exp_start   (exp_start),
        .exp_key     (exp_key),
        .exp_rcon    (exp_rcon),
        .exp_key_out (exp_key_out),
        .rk_rd_en    (rk_rd_en),
        .rk_idx      (rk_idx),
        .rk_data     (rk_data),
        .rk_valid    (rk_valid)
    );

    // ---------------- AES helpers ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // One expansion round, as the external datapath computes it.
    function automatic logic [127:0] ks_round(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = subword({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Whole-schedule reference using the 44-word recurrence.
    task automatic compute_ref(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = subword({t[23:0], t[31:24]}) ^ {rcon_tbl[i/4-1], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Attached datapath: two registered stages, enabled by exp_start.
    logic [127:0] dp_s1 = '0;
    logic [127:0] dp_s2 = '0;
    always @(posedge clk) begin
        if (exp_start) dp_s1 <= ks_round(exp_key, exp_rcon);
        dp_s2 <= dp_s1;
    end
    assign exp_key_out = dp_s2;

    // ---------------- stimulus tasks ----------------
    // Advance one clock; check the read port against the model of the
    // request presented before the edge.
    task automatic step(input string tag);
        logic en_q;
        en_q = rk_rd_en;
        if (rk_rd_en) begin
            if (m_ready && rk_idx <= 4'(NR)) m_rd_data = m_rk[rk_idx];
            else                             m_rd_data = '0;
        end
        @(posedge clk); #1;
        key_load = 1'b0;
        rk_rd_en = 1'b0;
        n_vec++;
        if (rk_valid !== en_q) begin
            n_err++;
            $display("FAIL %s rk_valid: got %b expected %b", tag, rk_valid, en_q);
        end
        n_vec++;
        if (rk_data !== m_rd_data) begin
            n_err++;
            $display("FAIL %s rk_data: got %h expected %h", tag, rk_data, m_rd_data);
        end
    endtask

    task automatic do_load(input logic [127:0] k, input logic rd, input logic [3:0] idx);
        key_in   = k;
        key_load = 1'b1;
        rk_rd_en = rd;
        rk_idx   = idx;
        step("load");
        m_ready = 1'b0;
    endtask

    // Checks every RUN cycle; optionally pulses an ignored key_load at
    // cycle ign, or stops before the edge of cycle stop_at.
    task automatic run_expand(input logic [127:0] k, input int ign, input int stop_at);
        int r;
        compute_ref(k);
        for (int c = 1; c <= NR * CPR; c++) begin
            r = (c - 1) / CPR;
            n_vec++;
            if (busy !== 1'b1 || ready !== 1'b0) begin
                n_err++;
                $display("FAIL run_flags c%0d: got busy=%b ready=%b expected busy=1 ready=0", c, busy, ready);
            end
            n_vec++;
            if (exp_start !== 1'b1) begin
                n_err++;
                $display("FAIL run_start c%0d: got %b expected 1", c, exp_start);
            end
            n_vec++;
            if (exp_rcon !== rcon_tbl[r]) begin
                n_err++;
                $display("FAIL run_rcon c%0d: got %h expected %h", c, exp_rcon, rcon_tbl[r]);
            end
            n_vec++;
            if (exp_key !== ref_rk[r]) begin
                n_err++;
                $display("FAIL run_key c%0d: got %h expected %h", c, exp_key, ref_rk[r]);
            end
            if (c == stop_at) return;
            rk_rd_en = 1'($urandom_range(0, 1));
            rk_idx   = 4'($urandom_range(0, 15));
            if (c == ign) begin
                key_load = 1'b1;
                key_in   = '0;
            end
            step("run_read");
        end
        m_ready = 1'b1;
        for (int i = 0; i <= NR; i++) m_rk[i] = ref_rk[i];
        n_vec++;
        if (busy !== 1'b0 || ready !== 1'b1 || exp_start !== 1'b0) begin
            n_err++;
            $display("FAIL done_flags: got busy=%b ready=%b start=%b expected 0 1 0", busy, ready, exp_start);
        end
    endtask

    task automatic read_all();
        for (int i = 0; i <= NR + 2; i++) begin
            rk_rd_en = 1'b1;
            rk_idx   = (i <= NR) ? 4'(i) : ((i == NR + 1) ? 4'd11 : 4'd15);
            step("read_seq");
        end
        step("read_tail");
        step("read_hold");
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || ready !== 1'b0 || exp_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b%b%b expected 000", busy, ready, exp_start);
        end
        n_vec++;
        if (exp_key !== '0 || exp_rcon !== 8'h00) begin
            n_err++;
            $display("FAIL reset_exp: got %h/%h expected 0/00", exp_key, exp_rcon);
        end
        n_vec++;
        if (rk_data !== '0 || rk_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rd: got %h/%b expected 0/0", rk_data, rk_valid);
        end
        reset = 1'b0;
        rk_rd_en = 1'b1;
        rk_idx   = 4'd0;
        step("idle_read");
    endtask

    task automatic test_fips();
        logic [127:0] k;
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        do_load(k, 1'b1, 4'd10);
        run_expand(k, 0, 0);
        rk_rd_en = 1'b1; rk_idx = 4'd1;
        step("fips_rd1");
        n_vec++;
        if (rk_data !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            n_err++;
            $display("FAIL fips_rk1: got %h expected a0fafe1788542cb123a339392a6c7605", rk_data);
        end
        rk_rd_en = 1'b1; rk_idx = 4'd10;
        step("fips_rd10");
        n_vec++;
        if (rk_data !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_err++;
            $display("FAIL fips_rk10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", rk_data);
        end
    endtask

    task automatic test_reads();
        read_all();
        for (int i = 0; i < 24; i++) begin
            rk_rd_en = 1'($urandom_range(0, 1));
            rk_idx   = 4'($urandom_range(0, 15));
            step("read_rand");
        end
    endtask

    task automatic test_ignore_load();
        logic [127:0] k;
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        do_load(k, 1'b0, 4'd0);
        run_expand(k, 5, 0);
        rk_rd_en = 1'b1; rk_idx = 4'd10;
        step("ign_rd10");
    endtask

    task automatic test_back_to_back();
        logic [127:0] k;
        for (int n = 0; n < 2; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            // Read on the load edge must still see the previous schedule.
            do_load(k, 1'b1, 4'(NR));
            n_vec++;
            if (ready !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL reload_flags: got ready=%b busy=%b expected 0 1", ready, busy);
            end
            run_expand(k, 0, 0);
            read_all();
        end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] k;
        k = {$urandom, $urandom, $urandom, $urandom};
        do_load(k, 1'b0, 4'd0);
        run_expand(k, 0, 12);
        reset = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || ready !== 1'b0 || exp_start !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_flags: got %b%b%b expected 000", busy, ready, exp_start);
        end
        n_vec++;
        if (exp_key !== '0) begin
            n_err++;
            $display("FAIL midreset_key: got %h expected 0", exp_key);
        end
        #1;
        reset = 1'b0;
        m_ready   = 1'b0;
        m_rd_data = '0;
        for (int i = 0; i <= NR; i++) m_rk[i] = '0;
        rk_rd_en = 1'b1; rk_idx = 4'd0;
        step("midreset_rd");
        k = {$urandom, $urandom, $urandom, $urandom};
        do_load(k, 1'b0, 4'd0);
        run_expand(k, 0, 0);
        read_all();
    endtask

`ifdef KS_ZEROIZE_EN
    task automatic test_zeroize();
        logic [127:0] k;
        zeroize  = 1'b1;
        key_load = 1'b1;
        key_in   = '1;
        rk_rd_en = 1'b1;
        rk_idx   = 4'd10;
        m_ready  = 1'b0;
        for (int i = 0; i <= NR; i++) m_rk[i] = '0;
        step("zeroize_edge");
        zeroize = 1'b0;
        n_vec++;
        if (ready !== 1'b0 || busy !== 1'b0 || exp_key !== '0 || exp_rcon !== 8'h01) begin
            n_err++;
            $display("FAIL zeroize_state: got r=%b b=%b key=%h rcon=%h expected 0 0 0 01",
                     ready, busy, exp_key, exp_rcon);
        end
        rk_rd_en = 1'b1; rk_idx = 4'd10;
        step("zeroize_rd");
        k = {$urandom, $urandom, $urandom, $urandom};
        do_load(k, 1'b0, 4'd0);
        run_expand(k, 0, 0);
        read_all();
    endtask
`endif

    initial begin
        reset    = 1'b1;
        key_load = 1'b0;
        key_in   = '0;
        rk_rd_en = 1'b0;
        rk_idx   = 4'd0;
`ifdef KS_ZEROIZE_EN
        zeroize  = 1'b0;
`endif
        for (int i = 0; i <= NR; i++) m_rk[i] = '0;
        build_sbox();
        test_reset();
        test_fips();
        test_reads();
        test_ignore_load();
        test_back_to_back();
        test_reset_mid_run();
`ifdef KS_ZEROIZE_EN
        test_zeroize();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
